// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - register offsets, ctrl bit positions and state types for the SPI FIFO controller
package spi_pkg;
    localparam logic [2:0] OFS_DATA   = 3'd0;
    localparam logic [2:0] OFS_STATUS = 3'd1;
    localparam logic [2:0] OFS_TX     = 3'd2;
    localparam logic [2:0] OFS_CTRL   = 3'd3;
    localparam logic [2:0] OFS_CMD    = 3'd4;

    localparam int CTRL_CPOL    = 16;
    localparam int CTRL_CPHA    = 17;
    localparam int CTRL_AUTO_SS = 18;
    localparam int CTRL_LSB     = 19;
    localparam logic [19:0] CTRL_RESET = 20'h00200;

    localparam int CMD_FLUSH_TX = 0;
    localparam int CMD_FLUSH_RX = 1;
    localparam int CMD_CLR_ERR  = 2;

    typedef enum logic [1:0] {IDLE, LOAD, XFER, STORE} eng_state_t;
    typedef enum logic [1:0] {M_IDLE, M_CPHA, M_P0, M_P1} mst_state_t;
endpackage

// File: rtl/spi_master_w.sv
// rtl/spi_master_w.sv - DW-bit SPI serialiser with selectable mode and bit order
module spi_master_w
    import spi_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] din,
    input  logic [15:0]   dvsr,
    input  logic          cpol,
    input  logic          cpha,
    input  logic          lsb_first,
    input  logic          start,
    input  logic          miso,
    output logic [DW-1:0] dout,
    output logic          done_tick,
    output logic          ready,
    output logic          sclk,
    output logic          mosi
);
    localparam int NW = $clog2(DW);

    mst_state_t    state, state_next;
    logic [15:0]   c_reg, c_next, dvsr_reg;
    logic [NW-1:0] n_reg, n_next;
    logic [DW-1:0] so_reg, so_next, si_reg, si_next;
    logic          cpol_reg, cpha_reg, lsb_reg;
    logic          p_clk;

    // Timing and mode are captured at start so ctrl writes only affect the next word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= M_IDLE;
            c_reg    <= '0;
            n_reg    <= '0;
            so_reg   <= '0;
            si_reg   <= '0;
            dvsr_reg <= '0;
            cpol_reg <= 1'b0;
            cpha_reg <= 1'b0;
            lsb_reg  <= 1'b0;
        end else begin
            state  <= state_next;
            c_reg  <= c_next;
            n_reg  <= n_next;
            so_reg <= so_next;
            si_reg <= si_next;
            if (state == M_IDLE && start) begin
                dvsr_reg <= dvsr;
                cpol_reg <= cpol;
                cpha_reg <= cpha;
                lsb_reg  <= lsb_first;
            end
        end
    end

    always_comb begin
        state_next = state;
        c_next     = c_reg;
        n_next     = n_reg;
        so_next    = so_reg;
        si_next    = si_reg;
        done_tick  = 1'b0;
        case (state)
            M_IDLE: begin
                if (start) begin
                    so_next    = din;
                    c_next     = '0;
                    n_next     = '0;
                    state_next = cpha ? M_CPHA : M_P0;
                end
            end
            M_CPHA: begin
                if (c_reg == dvsr_reg) begin
                    c_next     = '0;
                    state_next = M_P0;
                end else begin
                    c_next = c_reg + 16'd1;
                end
            end
            M_P0: begin
                if (c_reg == dvsr_reg) begin
                    si_next    = lsb_reg ? {miso, si_reg[DW-1:1]} : {si_reg[DW-2:0], miso};
                    c_next     = '0;
                    state_next = M_P1;
                end else begin
                    c_next = c_reg + 16'd1;
                end
            end
            M_P1: begin
                if (c_reg == dvsr_reg) begin
                    c_next = '0;
                    if (n_reg == NW'(DW - 1)) begin
                        done_tick  = 1'b1;
                        state_next = M_IDLE;
                    end else begin
                        so_next    = lsb_reg ? (so_reg >> 1) : (so_reg << 1);
                        n_next     = n_reg + NW'(1);
                        state_next = M_P0;
                    end
                end else begin
                    c_next = c_reg + 16'd1;
                end
            end
            default: state_next = M_IDLE;
        endcase
    end

    // Sampling always happens at the P0->P1 boundary; cpha only moves where sclk toggles.
    assign p_clk = (state == M_P1 && !cpha_reg) || (state == M_P0 && cpha_reg);
    assign sclk  = (state == M_IDLE) ? cpol : (cpol_reg ^ p_clk);
    assign mosi  = lsb_reg ? so_reg[0] : so_reg[DW-1];
    assign dout  = si_reg;
    assign ready = (state == M_IDLE);
endmodule

// File: rtl/spi_fifo_core.sv
// rtl/spi_fifo_core.sv - MMIO SPI controller with TX/RX FIFOs, auto slave select and sticky errors
module spi_fifo_core
    import spi_pkg::*;
#(
    parameter int S  = 2,
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          read,
    input  logic          write,
    input  logic [4:0]    addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    input  logic          spi_miso,
    output logic          spi_mosi,
    output logic          spi_sclk,
    output logic [S-1:0]  spi_ss_n
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};

    eng_state_t    state, state_next;
    logic [19:0]   ctrl;
    logic [S-1:0]  ss_n_reg;
    logic          tx_ovf, rx_ovf;

    logic [DW-1:0] tx_mem [DEPTH];
    logic [DW-1:0] rx_mem [DEPTH];
    logic [AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [AW:0]   tx_count, rx_count;
    logic          tx_empty, tx_full, rx_empty, rx_full;

    logic [2:0]    ofs;
    logic          wr_en, rd_en;
    logic          tx_push_req, tx_push, tx_pop, tx_flush;
    logic          rx_push, rx_pop, rx_flush, clr_err;
    logic          busy, mst_done, mst_ready;
    logic [DW-1:0] mst_dout;
    logic [31:0]   status;
    logic          unused_bits;

    assign ofs   = addr[2:0];
    assign wr_en = cs && write;
    assign rd_en = cs && read;
    assign unused_bits = ^{addr[4:3], wr_data[31:20]};

    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == CNT_FULL);
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == CNT_FULL);

    assign tx_push_req = wr_en && ofs == OFS_TX;
    assign tx_pop      = (state == LOAD) && !tx_empty;
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_flush    = wr_en && ofs == OFS_CMD && wr_data[CMD_FLUSH_TX];
    assign rx_pop      = rd_en && ofs == OFS_DATA && !rx_empty;
    assign rx_push     = (state == STORE) && (!rx_full || rx_pop);
    assign rx_flush    = wr_en && ofs == OFS_CMD && wr_data[CMD_FLUSH_RX];
    assign clr_err     = wr_en && ofs == OFS_CMD && wr_data[CMD_CLR_ERR];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else if (tx_flush) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + AW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
            tx_count <= tx_count + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push && !tx_flush) tx_mem[tx_wptr] <= wr_data[DW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else if (rx_flush) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + AW'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
            rx_count <= rx_count + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push && !rx_flush) rx_mem[rx_wptr] <= mst_dout;
    end

    // A flag clear in the same cycle as a new error wins; software re-reads status afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl     <= CTRL_RESET;
            ss_n_reg <= '1;
            tx_ovf   <= 1'b0;
            rx_ovf   <= 1'b0;
        end else begin
            if (wr_en && ofs == OFS_CTRL)   ctrl     <= wr_data[19:0];
            if (wr_en && ofs == OFS_STATUS) ss_n_reg <= wr_data[S-1:0];
            if (clr_err) begin
                tx_ovf <= 1'b0;
                rx_ovf <= 1'b0;
            end else begin
                if (tx_push_req && !tx_push)   tx_ovf <= 1'b1;
                if (state == STORE && !rx_push) rx_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!tx_empty && mst_ready) state_next = LOAD;
            LOAD:    state_next = XFER;
            XFER:    if (mst_done) state_next = STORE;
            STORE:   state_next = tx_empty ? IDLE : LOAD;
            default: state_next = IDLE;
        endcase
    end

    spi_master_w #(.DW(DW)) u_master (
        .clk       (clk),
        .reset     (reset),
        .din       (tx_mem[tx_rptr]),
        .dvsr      (ctrl[15:0]),
        .cpol      (ctrl[CTRL_CPOL]),
        .cpha      (ctrl[CTRL_CPHA]),
        .lsb_first (ctrl[CTRL_LSB]),
        .start     (state == LOAD),
        .miso      (spi_miso),
        .dout      (mst_dout),
        .done_tick (mst_done),
        .ready     (mst_ready),
        .sclk      (spi_sclk),
        .mosi      (spi_mosi)
    );

    assign busy     = (state != IDLE);
    assign spi_ss_n = (ctrl[CTRL_AUTO_SS] && state == IDLE) ? '1 : ss_n_reg;
    assign status   = {8'd0, 8'(rx_count), 8'(tx_count), 1'b0, tx_ovf, rx_ovf, busy,
                       tx_full, tx_empty, rx_full, rx_empty};

    always_comb begin
        rd_data = '0;
        case (ofs)
            OFS_DATA:   if (!rx_empty) rd_data[DW-1:0] = rx_mem[rx_rptr];
            OFS_STATUS: rd_data = status;
            default:    rd_data = '0;
        endcase
    end
endmodule
